// File: rtl/hamming_stream_if.sv
// Handshake and data bundle for hamming_stream: start, slice stream in, distance out.
// The optional threshold compare signals exist only when HAMMING_STREAM_THRESH_EN is defined.
interface hamming_stream_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  g_input;
    logic [W-1:0]  e_input;
    logic [CW-1:0] o;
    logic          o_valid;
    logic          busy;
`ifdef HAMMING_STREAM_THRESH_EN
    logic [CW-1:0] thresh;
    logic          match;
`endif

    modport master (
        output start, in_valid, g_input, e_input,
`ifdef HAMMING_STREAM_THRESH_EN
        output thresh,
        input  match,
`endif
        input  in_ready, o, o_valid, busy
    );

    modport slave (
        input  start, in_valid, g_input, e_input,
`ifdef HAMMING_STREAM_THRESH_EN
        input  thresh,
        output match,
`endif
        output in_ready, o, o_valid, busy
    );
endinterface

// File: rtl/hamming_stream.sv
// Multi-beat Hamming distance engine: sums popcount(g ^ e) over N/W slices.
// Optional feature macro: HAMMING_STREAM_THRESH_EN (adds thresh/match compare).
module hamming_stream #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    hamming_stream_if.slave bus
);
    localparam int CW    = $clog2(N + 1);
    localparam int BEATS = N / W;
    localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if ((N % W) != 0) begin : g_bad_width
            $error("hamming_stream: N must be a multiple of W");
        end
    endgenerate

    function automatic logic [CW-1:0] popcount_f(input logic [W-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [CW-1:0]   acc_r;
    logic [CNTW-1:0] cnt_r;
    logic [CW-1:0]   o_r;
    logic            o_valid_r;
    logic            in_ready_r;
    logic            busy_r;
    logic            accept_s;
    logic            last_s;
    logic [CW-1:0]   pc_s;
    logic [CW-1:0]   sum_s;
`ifdef HAMMING_STREAM_THRESH_EN
    logic [CW-1:0]   thresh_r;
    logic            match_r;
`endif

    assign accept_s = (state_r == ST_ACC) && bus.in_valid;
    assign last_s   = accept_s && (cnt_r == CNTW'(BEATS - 1));
    assign pc_s     = popcount_f(bus.g_input ^ bus.e_input);
    assign sum_s    = acc_r + pc_s;

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nxt_s = ST_ACC;
                else           state_nxt_s = ST_IDLE;
            end
            ST_ACC: begin
                if (last_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_ACC;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            o_valid_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_ACC);
            busy_r     <= (state_nxt_s == ST_ACC) || (state_nxt_s == ST_DONE);
            o_valid_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Accumulator, beat counter and result; o only moves on the final beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {CW{1'b0}};
            cnt_r <= {CNTW{1'b0}};
            o_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_r <= {CW{1'b0}};
                        cnt_r <= {CNTW{1'b0}};
                    end
                end
                ST_ACC: begin
                    if (last_s) begin
                        o_r <= sum_s;
                    end else if (accept_s) begin
                        acc_r <= sum_s;
                        cnt_r <= cnt_r + CNTW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HAMMING_STREAM_THRESH_EN
    // Threshold captured at start; match is produced alongside o
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_r <= {CW{1'b0}};
            match_r  <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && bus.start) begin
                thresh_r <= bus.thresh;
            end
            if (last_s) begin
                match_r <= (sum_s <= thresh_r);
            end
        end
    end

    assign bus.match = match_r;
`endif

    assign bus.o        = o_r;
    assign bus.o_valid  = o_valid_r;
    assign bus.in_ready = in_ready_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_hamming_stream.sv
// Directed bench for hamming_stream: single-beat table on N=8/W=8, multi-beat sequences on N=16/W=4.
module tb_hamming_stream;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hamming_stream_if #(.W(8), .CW(4)) if8 ();
    hamming_stream_if #(.W(4), .CW(5)) if16 ();

    hamming_stream #(.N(8),  .W(8)) u8  (.clk(clk), .rst(rst), .bus(if8));
    hamming_stream #(.N(16), .W(4)) u16 (.clk(clk), .rst(rst), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [7:0] e;
        logic [3:0] th;
        logic [3:0] exp_o;
        logic       exp_m;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic op8(input vec_t v);
        if8.start = 1'b1;
`ifdef HAMMING_STREAM_THRESH_EN
        if8.thresh = v.th;
`endif
        step();
        if8.start = 1'b0;
        check("op8 in_ready in ACC", 32'(if8.in_ready), 32'd1);
        if8.in_valid = 1'b1;
        if8.g_input  = v.g;
        if8.e_input  = v.e;
        step();
        if8.in_valid = 1'b0;
        check("op8 o_valid", 32'(if8.o_valid), 32'd1);
        check("op8 o", 32'(if8.o), 32'(v.exp_o));
`ifdef HAMMING_STREAM_THRESH_EN
        check("op8 match", 32'(if8.match), 32'(v.exp_m));
`endif
        step();
        check("op8 o_valid pulse ends", 32'(if8.o_valid), 32'd0);
        check("op8 o holds", 32'(if8.o), 32'(v.exp_o));
    endtask

    task automatic beat16(input logic [3:0] x, input logic valid);
        if16.in_valid = valid;
        if16.g_input  = x ^ 4'h5;
        if16.e_input  = 4'h5;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{8'hFF, 8'h0F, 4'd3, 4'd4, 1'b0};
        vecs[1] = '{8'hAA, 8'h55, 4'd8, 4'd8, 1'b1};
        vecs[2] = '{8'h5A, 8'h5A, 4'd0, 4'd0, 1'b1};
        vecs[3] = '{8'h07, 8'h00, 4'd3, 4'd3, 1'b1};
        vecs[4] = '{8'h0F, 8'h00, 4'd3, 4'd4, 1'b0};
        vecs[5] = '{8'h81, 8'h00, 4'd1, 4'd2, 1'b0};
        vecs[6] = '{8'h3C, 8'h0C, 4'd2, 4'd2, 1'b1};
        vecs[7] = '{8'hFE, 8'h01, 4'd7, 4'd8, 1'b0};

        if8.start = 1'b0;  if8.in_valid = 1'b0;  if8.g_input = 8'h00;  if8.e_input = 8'h00;
        if16.start = 1'b0; if16.in_valid = 1'b0; if16.g_input = 4'h0;  if16.e_input = 4'h0;
`ifdef HAMMING_STREAM_THRESH_EN
        if8.thresh = 4'd0;
        if16.thresh = 5'd0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset o", 32'(if8.o), 32'd0);
        check("reset o_valid", 32'(if8.o_valid), 32'd0);
        check("reset in_ready", 32'(if8.in_ready), 32'd0);
        check("reset busy", 32'(if8.busy), 32'd0);
        check("reset o16", 32'(if16.o), 32'd0);
`ifdef HAMMING_STREAM_THRESH_EN
        check("reset match", 32'(if8.match), 32'd0);
`endif
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            op8(vecs[i]);
        end

        // in_valid in IDLE and on the start edge must not consume a slice
        if8.in_valid = 1'b1; if8.g_input = 8'hFF; if8.e_input = 8'h00;
        step();
        step();
        check("idle in_valid busy", 32'(if8.busy), 32'd0);
        check("idle in_valid no o_valid", 32'(if8.o_valid), 32'd0);
        check("idle in_ready", 32'(if8.in_ready), 32'd0);
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        if8.g_input = 8'h03;
        step();
        if8.in_valid = 1'b0;
        check("idle slice ignored o_valid", 32'(if8.o_valid), 32'd1);
        check("idle slice ignored o", 32'(if8.o), 32'd2);
        step();

        // N=16/W=4 with a bubble between beats 2 and 3
        if16.start = 1'b1;
        step();
        if16.start = 1'b0;
        beat16(4'hF, 1'b1); step();
        check("bubble o_valid early", 32'(if16.o_valid), 32'd0);
        beat16(4'h1, 1'b1); step();
        beat16(4'hF, 1'b0); step();
        check("bubble intermediate hidden", 32'(if16.o), 32'd0);
        check("bubble busy", 32'(if16.busy), 32'd1);
        beat16(4'h0, 1'b1); step();
        check("bubble o_valid cycle 4", 32'(if16.o_valid), 32'd0);
        beat16(4'h7, 1'b1); step();
        beat16(4'h0, 1'b0);
        check("bubble o_valid cycle 5", 32'(if16.o_valid), 32'd1);
        check("bubble o", 32'(if16.o), 32'd8);
        step();
        check("bubble pulse ends", 32'(if16.o_valid), 32'd0);

        // reset mid-operation aborts without a result
        if16.start = 1'b1;
        step();
        if16.start = 1'b0;
        beat16(4'hF, 1'b1); step();
        beat16(4'hF, 1'b1); step();
        beat16(4'h0, 1'b0);
        rst = 1'b1;
        #2;
        check("abort o cleared", 32'(if16.o), 32'd0);
        check("abort busy", 32'(if16.busy), 32'd0);
        check("abort in_ready", 32'(if16.in_ready), 32'd0);
        step();
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (if16.o_valid) seen++;
            end
            check("abort no o_valid", 32'(seen), 32'd0);
        end
        if16.start = 1'b1;
        step();
        if16.start = 1'b0;
        begin
            int n;
            n = 0;
            for (int i = 0; i < 4; i++) begin
                beat16(4'h1, 1'b1);
                step();
                n++;
            end
            beat16(4'h0, 1'b0);
            while (!if16.o_valid && n < 20) begin
                step();
                n++;
            end
            check("fresh op latency", 32'(n), 32'd4);
            check("fresh op o", 32'(if16.o), 32'd4);
        end
        step();

        // start held high: ignored in ACC and DONE, re-accepted after DONE
        if8.start = 1'b1;
        step();
        check("held start busy", 32'(if8.busy), 32'd1);
        step();
        check("held start stays ACC", 32'(if8.in_ready), 32'd1);
        check("held start o old", 32'(if8.o), 32'd0);
        if8.in_valid = 1'b1; if8.g_input = 8'hFF; if8.e_input = 8'h00;
        step();
        if8.in_valid = 1'b0;
        check("held start done o_valid", 32'(if8.o_valid), 32'd1);
        check("held start done o", 32'(if8.o), 32'd8);
        check("held start done in_ready", 32'(if8.in_ready), 32'd0);
        step();
        check("held start idle busy", 32'(if8.busy), 32'd0);
        check("held start idle o", 32'(if8.o), 32'd8);
        step();
        check("held start restart in_ready", 32'(if8.in_ready), 32'd1);
        check("held start restart o holds", 32'(if8.o), 32'd8);
        if8.start = 1'b0;
        if8.in_valid = 1'b1; if8.g_input = 8'h0F; if8.e_input = 8'h00;
        step();
        if8.in_valid = 1'b0;
        check("held start second o_valid", 32'(if8.o_valid), 32'd1);
        check("held start second o", 32'(if8.o), 32'd4);
        step();
        check("held start second pulse ends", 32'(if8.o_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
